// File: rtl/recon_chroma8x8.sv
`default_nettype none
// ============================================================================
// Module   : recon_chroma8x8
// Brief    : 8x8 chroma block reconstruction. The residual block and the
//            selected prediction block are captured on start. Reconstructed
//            rows (pred + residual, clipped to 0..PIX_MAX) are then emitted
//            one per valid/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
module recon_chroma8x8 #(
  parameter int RES_W   = 9,
  parameter int PIX_MAX = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic                 start,
  input  logic [1:0]           mode,
  input  logic [64*RES_W-1:0]  res,
  input  logic [511:0]         vpred,
  input  logic [511:0]         hpred,
  input  logic [511:0]         dcpred,
  output logic [63:0]          out_row,
  output logic [2:0]           out_idx,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_run  = 2'd1;
  localparam logic [1:0] c_st_done = 2'd2;

  // Two guard bits above the wider operand keep pred + res free of overflow
  localparam int                         c_sum_w    = ((RES_W > 8) ? RES_W : 8) + 2;
  localparam logic signed [c_sum_w-1:0]  c_pix_max  = c_sum_w'(PIX_MAX);
  localparam logic [7:0]                 c_pix_max8 = 8'(PIX_MAX);

  logic [1:0]              r_state;
  logic [1:0]              w_state_nxt;
  logic [2:0]              r_row;
  logic [2:0]              w_row_nxt;
  logic                    r_valid;
  logic                    w_valid_nxt;
  logic                    r_done;
  logic                    w_done_nxt;
  logic                    r_err;
  logic                    w_err_nxt;
  logic                    w_capture;
  logic                    w_reject;
  logic                    w_hs;
  logic                    w_last;

  // Block buffers; deliberately not reset, their contents are masked until the next capture
  logic signed [RES_W-1:0] r_res_buf  [64];
  logic [7:0]              r_pred_buf [64];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= c_st_idle;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic; DONE lasts a single enabled cycle
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_idle: if (w_capture)       w_state_nxt = c_st_run;
      c_st_run:  if (w_hs && w_last)  w_state_nxt = c_st_done;
      c_st_done: if (enable)          w_state_nxt = c_st_idle;
      default:                        w_state_nxt = c_st_idle;
    endcase
  end

  // Output/control decode: capture, reject, handshake and next register values
  always_comb begin
    w_capture   = enable && (r_state == c_st_idle) && start && (mode != 2'd3);
    w_reject    = enable && (r_state == c_st_idle) && start && (mode == 2'd3);
    w_hs        = enable && (r_state == c_st_run) && r_valid && out_ready;
    w_last      = (r_row == 3'd7);
    w_row_nxt   = r_row;
    w_valid_nxt = r_valid;
    w_done_nxt  = r_done;
    w_err_nxt   = r_err;
    if (w_capture) begin
      w_row_nxt   = 3'd0;
      w_valid_nxt = 1'b1;
    end else if (w_hs) begin
      w_row_nxt   = r_row + 3'd1;
      w_valid_nxt = !w_last;
    end
    if (enable) begin
      w_done_nxt = w_hs && w_last;
      w_err_nxt  = w_reject;
    end
  end

  // Registered row index and the registered valid/done/err outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_row   <= 3'd0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_row   <= w_row_nxt;
      r_valid <= w_valid_nxt;
      r_done  <= w_done_nxt;
      r_err   <= w_err_nxt;
    end
  end

  // Capture the residual block and the prediction block chosen by mode
  always_ff @(posedge clk) begin
    if (w_capture) begin
      for (int i = 0; i < 64; i++) begin
        r_res_buf[i] <= res[i*RES_W +: RES_W];
        case (mode)
          2'd0:    r_pred_buf[i] <= vpred[i*8 +: 8];
          2'd1:    r_pred_buf[i] <= hpred[i*8 +: 8];
          default: r_pred_buf[i] <= dcpred[i*8 +: 8];
        endcase
      end
    end
  end

  // Per-column reconstruction of the current row from the captured buffers only
  for (genvar c = 0; c < 8; c++) begin : g_col
    localparam logic [2:0] c_col = 3'(c);
    logic [5:0]                w_sel;
    logic signed [c_sum_w-1:0] w_sum;
    logic [7:0]                w_pix;

    assign w_sel = {r_row, c_col};
    assign w_sum = $signed({{(c_sum_w-8){1'b0}}, r_pred_buf[w_sel]})
                 + $signed({{(c_sum_w-RES_W){r_res_buf[w_sel][RES_W-1]}}, r_res_buf[w_sel]});

    // Clip the sum into 0..PIX_MAX
    always_comb begin
      if (w_sum[c_sum_w-1])       w_pix = 8'd0;
      else if (w_sum > c_pix_max) w_pix = c_pix_max8;
      else                        w_pix = w_sum[7:0];
    end

    // Column 0 occupies the least significant byte; masked when no row is valid
    assign out_row[8*c +: 8] = r_valid ? w_pix : 8'd0;
  end

  assign out_idx   = r_valid ? r_row : 3'd0;
  assign out_valid = r_valid;
  assign busy      = (r_state != c_st_idle);
  assign done      = r_done;
  assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_recon_chroma8x8.sv
`default_nettype none
// ============================================================================
// Module   : tb_recon_chroma8x8
// Brief    : Self-checking bench for recon_chroma8x8 with a pixel-level
//            reference model (pred + residual, clipped) and a handshake-counted
//            expected row index.
// Revision : 1.0 - initial release
// ============================================================================
module tb_recon_chroma8x8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enable;
  logic          start;
  logic [1:0]    mode;
  logic [575:0]  res;
  logic [511:0]  vpred;
  logic [511:0]  hpred;
  logic [511:0]  dcpred;
  logic [63:0]   out_row;
  logic [2:0]    out_idx;
  logic          out_valid;
  logic          out_ready;
  logic          busy;
  logic          done;
  logic          err;

  int errors = 0;
  int checks = 0;
  int exp_pix [64];

  always #5 clk = ~clk;

  recon_chroma8x8 #(.RES_W(9), .PIX_MAX(255)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .start     (start),
    .mode      (mode),
    .res       (res),
    .vpred     (vpred),
    .hpred     (hpred),
    .dcpred    (dcpred),
    .out_row   (out_row),
    .out_idx   (out_idx),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic int clip(input int s);
    if (s < 0)   return 0;
    if (s > 255) return 255;
    return s;
  endfunction

  function automatic logic [63:0] model_row(input int r);
    logic [63:0] v;
    for (int c = 0; c < 8; c++) v[8*c +: 8] = 8'(exp_pix[8*r + c]);
    return v;
  endfunction

  task automatic randomize_inputs();
    for (int i = 0; i < 64; i++) begin
      res[i*9 +: 9]    = 9'($urandom_range(0, 511));
      vpred[i*8 +: 8]  = 8'($urandom_range(0, 255));
      hpred[i*8 +: 8]  = 8'($urandom_range(0, 255));
      dcpred[i*8 +: 8] = 8'($urandom_range(0, 255));
    end
  endtask

  // Computes the expected block, issues start and scrambles inputs after capture
  task automatic start_block(input logic [1:0] m, input string tag);
    int p;
    int r;
    for (int i = 0; i < 64; i++) begin
      case (m)
        2'd0:    p = int'(vpred[i*8 +: 8]);
        2'd1:    p = int'(hpred[i*8 +: 8]);
        default: p = int'(dcpred[i*8 +: 8]);
      endcase
      r = int'($signed(res[i*9 +: 9]));
      exp_pix[i] = clip(p + r);
    end
    enable = 1'b1;
    start  = 1'b1;
    mode   = m;
    step();
    start = 1'b0;
    randomize_inputs();
    chk({tag, "_valid0"}, 64'(out_valid), 64'd1);
    chk({tag, "_idx0"},   64'(out_idx),   64'd0);
    chk({tag, "_busy0"},  64'(busy),      64'd1);
    chk({tag, "_err0"},   64'(err),       64'd0);
    chk({tag, "_row0"},   out_row,        model_row(0));
  endtask

  // rk: 0 ready always, 1 pattern 1,0,0 repeating, 2 random
  // ek: 0 enable always, 1 enable low 3 cycles on row 2, 2 random
  task automatic drain(input int rk, input int ek, input bit spam, input string tag);
    int   row  = 0;
    int   cyc  = 0;
    int   hold = 0;
    logic rdy;
    logic en;
    while (row < 8) begin
      case (rk)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 3 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      case (ek)
        0: en = 1'b1;
        1: begin
          en = !(row == 2 && hold < 3);
          if (!en) hold++;
        end
        default: en = ($urandom_range(0, 3) != 0);
      endcase
      out_ready = rdy;
      enable    = en;
      if (spam) begin
        start = 1'b1;
        mode  = 2'($urandom_range(0, 3));
      end
      step();
      cyc++;
      if (rdy && en) row++;
      if (row < 8) begin
        chk({tag, "_valid"}, 64'(out_valid), 64'd1);
        chk({tag, "_idx"},   64'(out_idx),   64'(row));
        chk({tag, "_row"},   out_row,        model_row(row));
        chk({tag, "_busy"},  64'(busy),      64'd1);
        chk({tag, "_done"},  64'(done),      64'd0);
        chk({tag, "_err"},   64'(err),       64'd0);
      end
    end
    enable    = 1'b1;
    out_ready = 1'($urandom_range(0, 1));
    chk({tag, "_dn_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_dn_done"},  64'(done),      64'd1);
    chk({tag, "_dn_busy"},  64'(busy),      64'd1);
    chk({tag, "_dn_row"},   out_row,        64'd0);
    chk({tag, "_dn_err"},   64'(err),       64'd0);
    step();
    chk({tag, "_id_done"},  64'(done),      64'd0);
    chk({tag, "_id_busy"},  64'(busy),      64'd0);
    chk({tag, "_id_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_id_err"},   64'(err),       64'd0);
    start = 1'b0;
  endtask

  // Global time limit so the bench always ends
  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n     = 1'b0;
    enable    = 1'b1;
    start     = 1'b0;
    mode      = 2'd0;
    out_ready = 1'b0;
    randomize_inputs();
    step();
    step();
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_busy",  64'(busy),      64'd0);
    chk("rst_done",  64'(done),      64'd0);
    chk("rst_err",   64'(err),       64'd0);
    chk("rst_row",   out_row,        64'd0);
    chk("rst_idx",   64'(out_idx),   64'd0);
    rst_n = 1'b1;
    step();
    chk("idle_valid", 64'(out_valid), 64'd0);

    // Vertical, flat data: every pixel 100 + 5
    for (int i = 0; i < 64; i++) begin
      vpred[i*8 +: 8] = 8'd100;
      res[i*9 +: 9]   = 9'd5;
    end
    start_block(2'd0, "vert");
    chk("vert_px105", out_row, {8{8'd105}});
    drain(0, 0, 0, "vert");

    // DC with clipping at both ends, issued back-to-back in the first idle cycle
    randomize_inputs();
    for (int i = 0; i < 64; i++) dcpred[i*8 +: 8] = 8'd250;
    res[0 +: 9]  = 9'd20;
    res[9 +: 9]  = 9'h101;
    res[18 +: 9] = 9'd0;
    start_block(2'd2, "dc");
    chk("dc_clip3", 64'(out_row[23:0]), 64'hFA00FF);
    drain(2, 0, 1, "dc");

    // Horizontal with out_ready 1,0,0 pattern
    randomize_inputs();
    start_block(2'd1, "horz");
    drain(1, 0, 0, "horz");

    // Invalid mode in idle
    start = 1'b1;
    mode  = 2'd3;
    step();
    start = 1'b0;
    chk("inv_err1",   64'(err),       64'd1);
    chk("inv_busy1",  64'(busy),      64'd0);
    chk("inv_valid1", 64'(out_valid), 64'd0);
    step();
    chk("inv_err2",   64'(err),       64'd0);
    chk("inv_busy2",  64'(busy),      64'd0);
    chk("inv_valid2", 64'(out_valid), 64'd0);

    // Start with enable low is not taken
    enable = 1'b0;
    start  = 1'b1;
    mode   = 2'd0;
    step();
    start  = 1'b0;
    enable = 1'b1;
    chk("en0_busy",  64'(busy),      64'd0);
    chk("en0_valid", 64'(out_valid), 64'd0);

    // Enable low for three cycles on row 2
    randomize_inputs();
    start_block(2'($urandom_range(0, 2)), "stall");
    drain(0, 1, 0, "stall");

    // Reset in the middle of row 3
    randomize_inputs();
    start_block(2'd0, "mid");
    out_ready = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      step();
      chk("mid_idx", 64'(out_idx), 64'(k));
      chk("mid_row", out_row,      model_row(k));
    end
    out_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 64'(out_valid), 64'd0);
    chk("arst_busy",  64'(busy),      64'd0);
    chk("arst_row",   out_row,        64'd0);
    chk("arst_idx",   64'(out_idx),   64'd0);
    chk("arst_done",  64'(done),      64'd0);
    chk("arst_err",   64'(err),       64'd0);
    step();
    rst_n = 1'b1;
    step();
    chk("post_valid", 64'(out_valid), 64'd0);
    chk("post_busy",  64'(busy),      64'd0);
    chk("post_row",   out_row,        64'd0);
    randomize_inputs();
    start_block(2'd0, "after_rst");
    drain(0, 0, 0, "after_rst");

    // Random blocks with random ready/enable and start spam while busy
    for (int b = 0; b < 6; b++) begin
      randomize_inputs();
      for (int g = $urandom_range(0, 2); g > 0; g--) step();
      start_block(2'($urandom_range(0, 2)), "rnd");
      drain(2, 2, 1'($urandom_range(0, 1)), "rnd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/recon_chroma8x8.md
RECON_CHROMA8X8 -- requirements
Module: recon_chroma8x8

Interface
REQ-001 Parameter RES_W, default 9: width in bits of each signed residual sample.
REQ-002 Parameter PIX_MAX, default 255: upper clip value for reconstructed pixels.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; clears all state immediately when low.
REQ-005 enable  input  1  when 0, state, row index and outputs hold and no handshake completes.
REQ-006 start  input  1  request to reconstruct one 8x8 chroma block; sampled only in IDLE.
REQ-007 mode  input  2  0 = vertical, 1 = horizontal, 2 = DC, 3 = invalid.
REQ-008 res  input  64 x RES_W signed  residual block, raster order (index = 8*row + col).
REQ-009 vpred, hpred, dcpred  input  64 x 8 each  unsigned prediction blocks, raster order.
REQ-010 out_row  output  8 x 8  reconstructed pixels of the current row, column 0 first.
REQ-011 out_idx  output  3  row number of out_row.
REQ-012 out_valid  output  1  out_row/out_idx hold a valid row.
REQ-013 out_ready  input  1  downstream accepts the row when high with out_valid.
REQ-014 busy  output  1  high in RUN and DONE.
REQ-015 done  output  1  one-cycle pulse after row 7 is accepted.
REQ-016 err  output  1  one-cycle pulse when start arrives in IDLE with mode 3.

Function
REQ-017 FSM states: IDLE, RUN, DONE; transitions occur only when enable=1.
REQ-018 IDLE, start=1, mode<=2: capture res and the prediction block selected by mode into internal buffers, set row index to 0, go to RUN.
REQ-019 IDLE, start=1, mode=3: capture nothing, assert err for the next cycle only, remain in IDLE.
REQ-020 Latency: out_valid rises in the cycle after the capturing edge, with out_idx=0.
REQ-021 Pixel arithmetic: sum = zero-extended pred + sign-extended res in at least RES_W+1 bits; output 0 if sum<0, PIX_MAX if sum>PIX_MAX, otherwise sum.
REQ-022 out_row SHALL be computed only from the captured buffers; input changes after capture have no effect on the block in flight.
REQ-023 RUN: a handshake completes on an edge where out_valid=1, out_ready=1 and enable=1; the row index then increments.
REQ-024 While out_valid=1 and no handshake completes, out_row and out_idx hold stable.
REQ-025 A handshake on row 7 moves the FSM to DONE; out_valid is 0 in DONE.
REQ-026 DONE: done=1 for exactly one cycle, then the FSM returns to IDLE.
REQ-027 start is ignored in RUN and DONE, with no capture and no err.
REQ-028 A new start may be accepted in the first IDLE cycle after DONE, so back-to-back blocks cost 10 cycles minimum.
REQ-029 out_valid, done and err SHALL be registered outputs.

Reset
REQ-030 On reset low: state=IDLE, row index=0, out_valid=0, busy=0, done=0, err=0, out_row all 0, out_idx=0, regardless of clock.
REQ-031 Reset asserted mid-block abandons the block; after release no stale row is presented and the next start is handled normally.
REQ-032 Internal buffers need not be cleared on reset, but their contents SHALL never be visible until a new capture.

Verification
REQ-033 Bench SHALL drive: mode=0, vpred all 100, res all +5, out_ready=1 -> rows 0..7 on 8 consecutive cycles, all pixels 105, out_idx 0..7, done pulse in the next cycle.
REQ-034 Bench SHALL drive: mode=2, dcpred all 250, res[0]=+20, res[1]=-255, res[2]=0 -> row 0 pixels 255, 0, 250.
REQ-035 Bench SHALL drive: mode=1, out_ready toggled 1,0,0,1,... -> each row held stable while out_ready=0, no row skipped or duplicated, done only after row 7 is accepted.
REQ-036 Bench SHALL drive: start with mode=3 in IDLE -> err=1 for one cycle, busy and out_valid stay 0.
REQ-037 Bench SHALL drive: reset low during row 3 of a block -> outputs zero at once; after release, a new start with mode=0 produces row 0 from the new data.
REQ-038 Bench SHALL drive: enable=0 for 3 cycles during row 2 with out_ready=1 -> row 2 held and out_idx stays 2; resumes on enable=1 and completes the block.
